parking_gate_ctrl: RTL and testbench

Entry/exit gate controller sitting directly upstream of the `parking` occupancy block. It debounces raw lane sensors, latches the badge class, and checks the vacancy flags that `parking` reports. It then emits the single-cycle `car_entered`/`car_exited` strobes and class bits that `parking` consumes, and drives the two barrier outputs.

---
 rtl/parking_gate_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_ctrl
// Brief    : Entry/exit lane gate controller feeding the parking occupancy
//            block; optional deny counter via PARKING_GATE_DENY_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BARRIER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       start,
    input  logic       entry_sensor,
    input  logic       entry_badge_uni,
    input  logic       exit_sensor,
    input  logic       exit_badge_uni,
    input  logic       uni_is_vacated_space,
    input  logic       is_vacated_space,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited,
    output logic       entry_barrier_open,
    output logic       exit_barrier_open,
    output logic       entry_denied
`ifdef PARKING_GATE_DENY_CNT_EN
    ,
    output logic [7:0] deny_count
`endif
);

    localparam logic [3:0] c_DB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] c_BAR_LOAD = 8'(BARRIER_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_CHECK      = 2'd1;
    localparam logic [1:0] c_ST_OPEN       = 2'd2;
    localparam logic [1:0] c_ST_WAIT_CLEAR = 2'd3;

    // Lane index 0 = entry, 1 = exit.
    logic [1:0] w_raw;
    logic [1:0] w_db;

    assign w_raw = {exit_sensor, entry_sensor};

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic [3:0] r_cnt;
        logic       r_state;

        always_ff @(posedge clk) begin
            if (start) begin
                r_cnt   <= 4'd0;
                r_state <= 1'b0;
            end else if (w_raw[gi] != r_state) begin
                if (r_cnt == c_DB_LAST) begin
                    r_state <= w_raw[gi];
                    r_cnt   <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_cnt <= 4'd0;
            end
        end

        assign w_db[gi] = r_state;
    end

    logic [1:0] r_entry_state, w_entry_state_nxt;
    logic [1:0] r_exit_state,  w_exit_state_nxt;
    logic       r_entry_cls,   w_entry_cls_nxt;
    logic       r_exit_cls,    w_exit_cls_nxt;
    logic [7:0] r_entry_cnt,   w_entry_cnt_nxt;
    logic [7:0] r_exit_cnt,    w_exit_cnt_nxt;

    logic w_car_entered_nxt;
    logic w_uni_entered_nxt;
    logic w_car_exited_nxt;
    logic w_uni_exited_nxt;
    logic w_entry_bar_nxt;
    logic w_exit_bar_nxt;
    logic w_denied_nxt;
    logic w_entry_grant;

    assign w_entry_grant = r_entry_cls ? uni_is_vacated_space : is_vacated_space;

    always_comb begin
        w_exit_state_nxt = r_exit_state;
        w_exit_cls_nxt   = r_exit_cls;
        w_exit_cnt_nxt   = r_exit_cnt;
        w_car_exited_nxt = 1'b0;
        w_uni_exited_nxt = 1'b0;
        w_exit_bar_nxt   = 1'b0;
        case (r_exit_state)
            c_ST_IDLE: begin
                if (w_db[1]) begin
                    w_exit_state_nxt = c_ST_CHECK;
                    w_exit_cls_nxt   = exit_badge_uni;
                end
            end
            c_ST_CHECK: begin
                w_car_exited_nxt = 1'b1;
                w_uni_exited_nxt = r_exit_cls;
                w_exit_bar_nxt   = 1'b1;
                w_exit_cnt_nxt   = c_BAR_LOAD;
                w_exit_state_nxt = c_ST_OPEN;
            end
            c_ST_OPEN: begin
                if (r_exit_cnt == 8'd0) begin
                    w_exit_state_nxt = c_ST_WAIT_CLEAR;
                end else begin
                    w_exit_cnt_nxt = r_exit_cnt - 8'd1;
                    w_exit_bar_nxt = 1'b1;
                end
            end
            default: begin
                if (!w_db[1]) begin
                    w_exit_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    // A granted entry colliding with an exit strobe waits in CHECK and
    // re-reads the vacancy flags on the following cycle.
    always_comb begin
        w_entry_state_nxt = r_entry_state;
        w_entry_cls_nxt   = r_entry_cls;
        w_entry_cnt_nxt   = r_entry_cnt;
        w_car_entered_nxt = 1'b0;
        w_uni_entered_nxt = 1'b0;
        w_entry_bar_nxt   = 1'b0;
        w_denied_nxt      = 1'b0;
        case (r_entry_state)
            c_ST_IDLE: begin
                if (w_db[0]) begin
                    w_entry_state_nxt = c_ST_CHECK;
                    w_entry_cls_nxt   = entry_badge_uni;
                end
            end
            c_ST_CHECK: begin
                if (!w_entry_grant) begin
                    w_denied_nxt      = 1'b1;
                    w_entry_state_nxt = c_ST_WAIT_CLEAR;
                end else if (!w_car_exited_nxt) begin
                    w_car_entered_nxt = 1'b1;
                    w_uni_entered_nxt = r_entry_cls;
                    w_entry_bar_nxt   = 1'b1;
                    w_entry_cnt_nxt   = c_BAR_LOAD;
                    w_entry_state_nxt = c_ST_OPEN;
                end
            end
            c_ST_OPEN: begin
                if (r_entry_cnt == 8'd0) begin
                    w_entry_state_nxt = c_ST_WAIT_CLEAR;
                end else begin
                    w_entry_cnt_nxt = r_entry_cnt - 8'd1;
                    w_entry_bar_nxt = 1'b1;
                end
            end
            default: begin
                if (!w_db[0]) begin
                    w_entry_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_entry_state      <= c_ST_IDLE;
            r_exit_state       <= c_ST_IDLE;
            r_entry_cls        <= 1'b0;
            r_exit_cls         <= 1'b0;
            r_entry_cnt        <= 8'd0;
            r_exit_cnt         <= 8'd0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            entry_barrier_open <= 1'b0;
            exit_barrier_open  <= 1'b0;
            entry_denied       <= 1'b0;
        end else begin
            r_entry_state      <= w_entry_state_nxt;
            r_exit_state       <= w_exit_state_nxt;
            r_entry_cls        <= w_entry_cls_nxt;
            r_exit_cls         <= w_exit_cls_nxt;
            r_entry_cnt        <= w_entry_cnt_nxt;
            r_exit_cnt         <= w_exit_cnt_nxt;
            car_entered        <= w_car_entered_nxt;
            is_uni_car_entered <= w_uni_entered_nxt;
            car_exited         <= w_car_exited_nxt;
            is_uni_car_exited  <= w_uni_exited_nxt;
            entry_barrier_open <= w_entry_bar_nxt;
            exit_barrier_open  <= w_exit_bar_nxt;
            entry_denied       <= w_denied_nxt;
        end
    end

`ifdef PARKING_GATE_DENY_CNT_EN
    always_ff @(posedge clk) begin
        if (start) begin
            deny_count <= 8'd0;
        end else if (w_denied_nxt && (deny_count != 8'hFF)) begin
            deny_count <= deny_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_gate_ctrl
// Brief    : Directed scoreboard bench for parking_gate_ctrl (D=4, B=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_gate_ctrl;

    localparam int c_DB  = 4;
    localparam int c_BAR = 8;

    logic clk = 1'b0;
    logic start;
    logic entry_sensor, entry_badge_uni, exit_sensor, exit_badge_uni;
    logic uni_is_vacated_space, is_vacated_space;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic entry_barrier_open, exit_barrier_open, entry_denied;
`ifdef PARKING_GATE_DENY_CNT_EN
    logic [7:0] deny_count;
`endif

    parking_gate_ctrl #(
        .DEBOUNCE_CYCLES (c_DB),
        .BARRIER_CYCLES  (c_BAR)
    ) u_dut (
        .clk                  (clk),
        .start                (start),
        .entry_sensor         (entry_sensor),
        .entry_badge_uni      (entry_badge_uni),
        .exit_sensor          (exit_sensor),
        .exit_badge_uni       (exit_badge_uni),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .entry_barrier_open   (entry_barrier_open),
        .exit_barrier_open    (exit_barrier_open),
        .entry_denied         (entry_denied)
`ifdef PARKING_GATE_DENY_CNT_EN
        ,
        .deny_count           (deny_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    // Expected output vector per edge, edge 1 = first edge sampling the new
    // stimulus: {entered, uni_entered, exited, uni_exited, ent_bar, ext_bar, denied}
    task automatic push_window(input string tag, input int n, input int ent_e,
                               input bit ent_uni, input int ext_e,
                               input bit ext_uni, input int den_e);
        for (int e = 1; e <= n; e++) begin
            exp_t x;
            x.tag = $sformatf("%s@%0d", tag, e);
            x.v = {ent_e == e, (ent_e == e) && ent_uni,
                   ext_e == e, (ext_e == e) && ext_uni,
                   (ent_e > 0) && (e >= ent_e) && (e < ent_e + c_BAR),
                   (ext_e > 0) && (e >= ext_e) && (e < ext_e + c_BAR),
                   den_e == e};
            exp_q.push_back(x);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t       x;
            logic [6:0] obs;
            @(posedge clk);
            #1;
            obs = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                   entry_barrier_open, exit_barrier_open, entry_denied};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty observed=%b required=<entry>", obs);
            end else begin
                x = exp_q.pop_front();
                assert (obs === x.v) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL %s observed=%b required=%b", x.tag, obs, x.v);
                end
            end
        end
    endtask

    task automatic check_deny(input string tag, input logic [7:0] req);
`ifdef PARKING_GATE_DENY_CNT_EN
        n_checks++;
        assert (deny_count === req) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d required=%0d", tag, deny_count, req);
        end
`else
        if (req === 8'hxx) $display("%s", tag);
`endif
    endtask

    task automatic drop_entry(input string tag);
        entry_sensor = 1'b0;
        push_window(tag, 8, 0, 0, 0, 0, 0);
        run(8);
    endtask

    logic [6:0] bounce_pat;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start                = 1'b1;
        entry_sensor         = 1'b1;
        entry_badge_uni      = 1'b0;
        exit_sensor          = 1'b0;
        exit_badge_uni       = 1'b0;
        uni_is_vacated_space = 1'b0;
        is_vacated_space     = 1'b1;

        // Reset with sensor high, then a general-class entry 6 edges later.
        push_window("reset", 3, 0, 0, 0, 0, 0);
        run(3);
        start = 1'b0;
        push_window("post_reset_gen", 20, 6, 0, 0, 0, 0);
        run(20);
        drop_entry("clear1");
        check_deny("deny_init", 8'd0);

        // Uni entry; badge changed after latching must not matter.
        entry_badge_uni      = 1'b1;
        uni_is_vacated_space = 1'b1;
        is_vacated_space     = 1'b0;
        entry_sensor         = 1'b1;
        push_window("uni_entry", 20, 6, 1, 0, 0, 0);
        run(5);
        entry_badge_uni = 1'b0;
        run(15);
        drop_entry("clear2");

        // Bounce: 1,1,0,1,1,1,0 never reaches 4 samples, then stable 1s.
        entry_badge_uni = 1'b1;
        bounce_pat      = 7'b0111011;
        push_window("bounce", 24, 13, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            entry_sensor = bounce_pat[i];
            run(1);
        end
        entry_sensor = 1'b1;
        run(17);
        drop_entry("clear3");

        // Denied: general badge, no general space (uni space free).
        entry_badge_uni      = 1'b0;
        uni_is_vacated_space = 1'b1;
        is_vacated_space     = 1'b0;
        entry_sensor         = 1'b1;
        push_window("deny_gen", 14, 0, 0, 0, 0, 6);
        run(14);
        check_deny("deny_one", 8'd1);
        drop_entry("clear4");

        // Denied: uni badge, no uni space (general space free).
        entry_badge_uni      = 1'b1;
        uni_is_vacated_space = 1'b0;
        is_vacated_space     = 1'b1;
        entry_sensor         = 1'b1;
        push_window("deny_uni", 14, 0, 0, 0, 0, 6);
        run(14);
        check_deny("deny_two", 8'd2);
        drop_entry("clear5");

        // Collision: exit wins at edge 6, entry follows at edge 7.
        entry_badge_uni      = 1'b0;
        is_vacated_space     = 1'b1;
        exit_badge_uni       = 1'b1;
        entry_sensor         = 1'b1;
        exit_sensor          = 1'b1;
        push_window("collision", 18, 7, 0, 6, 1, 0);
        run(18);
        exit_sensor = 1'b0;
        drop_entry("clear6");

        // Exit glitch of 3 samples, then a general-class exit.
        exit_badge_uni = 1'b0;
        exit_sensor    = 1'b1;
        push_window("exit_glitch", 3, 0, 0, 0, 0, 0);
        run(3);
        exit_sensor = 1'b0;
        push_window("exit_glitch_tail", 8, 0, 0, 0, 0, 0);
        run(8);
        exit_sensor = 1'b1;
        push_window("exit_gen", 16, 0, 0, 6, 0, 0);
        run(16);
        exit_sensor = 1'b0;
        push_window("clear7", 8, 0, 0, 0, 0, 0);
        run(8);

        // Reset at barrier cycle 3, sensor held: barrier drops, new event later.
        entry_badge_uni      = 1'b1;
        uni_is_vacated_space = 1'b1;
        entry_sensor         = 1'b1;
        push_window("mid_open", 8, 6, 1, 0, 0, 0);
        run(8);
        start = 1'b1;
        push_window("mid_open_rst", 2, 0, 0, 0, 0, 0);
        run(2);
        check_deny("deny_rst", 8'd0);
        start = 1'b0;
        push_window("after_rst", 16, 6, 1, 0, 0, 0);
        run(16);
        drop_entry("clear8");

        n_checks++;
        assert (exp_q.size() == 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
